// File: rtl/cs_key_pkg.sv
// Shared CS-Cipher key definitions: bank geometry, key-schedule constants,
// round-key type and the round-key sequencer state encoding.
package cs_key_pkg;

    localparam int N_KEYS = 9;
    localparam int RK_W   = 64;

    typedef logic [RK_W-1:0] rk_t;

    // Key-schedule constants consumed by key_sh.
    localparam rk_t CI [N_KEYS] = '{
        64'hb7e151628aed2a6a, 64'hbf7158809cf4f3c7, 64'h62e7160f38b4da56,
        64'ha784d9045190cfef, 64'h324e7738926cfbe5, 64'hf4bf8d8d8c31d763,
        64'hda06c80abb1185eb, 64'h4f7c7b5757f59584, 64'h90cfd47d7c19bb42
    };

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rk_seq_state_t;

endpackage

// File: rtl/cs_rk_sequencer_if.sv
// Round-key stream bus: valid/ready handshake carrying one 64-bit key,
// its bank index and an end-of-stream marker.
interface cs_rk_sequencer_if;
    import cs_key_pkg::*;

    logic       rk_valid;
    logic       rk_ready;
    rk_t        rk_data;
    logic [3:0] rk_idx;
    logic       rk_last;

    modport master (output rk_valid, rk_data, rk_idx, rk_last, input rk_ready);
    modport slave  (input rk_valid, rk_data, rk_idx, rk_last, output rk_ready);

endinterface

// File: rtl/cs_rk_sequencer.sv
// Captures the key_sh round-key bank and streams the nine round keys to the
// round datapath, ascending for encryption and descending for decryption.
module cs_rk_sequencer
    import cs_key_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   keys_ready,
    input  logic [N_KEYS*RK_W-1:0] round_keys,
    input  logic                   start,
    input  logic                   dir,
    input  logic                   flush,
    cs_rk_sequencer_if.master      rk,
    output logic                   busy,
    output logic                   keys_loaded,
    output logic                   err_no_keys,
    output logic                   load_drop
);

    localparam logic [3:0] IDX_MAX = 4'(N_KEYS - 1);

    rk_seq_state_t state, state_n;
    rk_t           bank [N_KEYS];
    logic [3:0]    idx, idx_n;
    logic          dir_q, dir_n;
    logic          kr_q;
    logic          load_edge, load_en;
    logic          err_n, drop_n;
    logic          is_last;

    assign load_edge = keys_ready & ~kr_q;
    assign is_last   = dir_q ? (idx == 4'd0) : (idx == IDX_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            dir_q       <= 1'b0;
            kr_q        <= 1'b0;
            keys_loaded <= 1'b0;
            err_no_keys <= 1'b0;
            load_drop   <= 1'b0;
            for (int i = 0; i < N_KEYS; i++) bank[i] <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            dir_q       <= dir_n;
            kr_q        <= keys_ready;
            err_no_keys <= err_n;
            load_drop   <= drop_n;
            if (load_en) begin
                keys_loaded <= 1'b1;
                for (int i = 0; i < N_KEYS; i++) bank[i] <= round_keys[i*RK_W +: RK_W];
            end
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        dir_n   = dir_q;
        load_en = 1'b0;
        err_n   = 1'b0;
        drop_n  = 1'b0;
        unique case (state)
            IDLE: begin
                load_en = load_edge;
                // A load edge in the same cycle as start makes the new bank usable at once.
                if (start) begin
                    if (keys_loaded || load_edge) begin
                        state_n = STREAM;
                        dir_n   = dir;
                        idx_n   = dir ? IDX_MAX : 4'd0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            STREAM: begin
                drop_n = load_edge;
                // flush outranks a coincident transfer: the stream ends either way.
                if (flush) begin
                    state_n = IDLE;
                end else if (rk.rk_ready) begin
                    if (is_last) state_n = IDLE;
                    else         idx_n   = dir_q ? idx - 4'd1 : idx + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy        = (state == STREAM);
    assign rk.rk_valid = busy;
    assign rk.rk_data  = busy ? bank[idx] : '0;
    assign rk.rk_idx   = busy ? idx : 4'd0;
    assign rk.rk_last  = busy & is_last;

endmodule
